// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ requesters.
// Define UART_ARB_TIMEOUT_EN to enable the tx_busy-rise watchdog (timeout_err).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 start_trigger,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 arb_busy,
  output logic                 timeout_err
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               start_q, start_d;
  logic [7:0]         data_q, data_d;
  logic               busy_q, busy_d;
  logic [IW-1:0]      gnt;
  logic               found;
  logic               expired;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction

  // Walk offsets from the far end so the closest requester to rr_q wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[wrap(int'(rr_q) + i)]) begin
        gnt   = wrap(int'(rr_q) + i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          data_d  = req_data[8*gnt +: 8];
          ack_d   = NUM_REQ'(1) << gnt;
          start_d = 1'b1;
          rr_d    = wrap(int'(gnt) + 1);
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  // Fires on the TIMEOUT_CYC-th WAIT_BUSY cycle still seeing tx_busy low.
  assign expired = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    to_d  = 1'b0;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT_BUSY && !tx_busy) begin
      cnt_d = cnt_q + CW'(1);
      to_d  = expired;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_err = to_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ack           = ack_q;
  assign start_trigger = start_q;
  assign tx_data       = data_q;
  assign arb_busy      = busy_q;
endmodule
